// File: rtl/oled_line_arbiter.sv
// oled_line_arbiter: round-robin owner of the OLED write/update port.
// Optional `OLED_ARB_AUTO_UPDATE_EN adds one display update per line.
module oled_line_arbiter #(
  parameter int N_REQ      = 2,
  parameter int LINE_CHARS = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     req_row,
  input  logic [128*N_REQ-1:0]   req_text,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   write_start,
  output logic [8:0]             write_base_addr,
  output logic [7:0]             write_ascii_data,
  input  logic                   write_ready,
  output logic                   update_start,
  output logic                   update_clear,
  input  logic                   update_ready
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [OW-1:0] LAST = OW'(N_REQ - 1);
  localparam logic [4:0] LC = 5'(LINE_CHARS);

  typedef enum logic [2:0] {
    IDLE, WR_ISSUE, WR_HOLD, WR_WAIT,
    UPD_ISSUE, UPD_HOLD, UPD_WAIT, FINISH
  } state_t;

  state_t            state;
  logic [OW-1:0]     rr;
  logic [OW-1:0]     owner;
  logic [1:0]        row_q;
  logic [127:0]      text_q;
  logic [4:0]        col;
  logic [4:0]        col_nx;

  logic              pick_vld;
  logic [OW-1:0]     pick_idx;
  logic [OW:0]       sum;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]  req_rot;
  logic [N_REQ-1:0]  pick_oh;
  logic [N_REQ-1:0]  owner_oh;
  logic [1:0]        pick_row;
  logic [127:0]      pick_text;
  logic [7:0]        cur_char;

  assign col_nx = col + 5'd1;

  // Rotate requests so the rr pointer is bit 0, take the first set bit.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    sum      = '0;
    req_dbl  = {req, req} >> rr;
    req_rot  = req_dbl[N_REQ-1:0];
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_vld && req_rot[k]) begin
        pick_vld = 1'b1;
        sum = {1'b0, rr} + (OW+1)'(k);
        if (sum >= (OW+1)'(N_REQ))
          sum = sum - (OW+1)'(N_REQ);
        pick_idx = sum[OW-1:0];
      end
    end
  end

  // Decode winner/owner indices and select the winner's row and text.
  always_comb begin
    pick_oh   = '0;
    owner_oh  = '0;
    pick_row  = '0;
    pick_text = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pick_oh[k]  = (pick_idx == OW'(k));
      owner_oh[k] = (owner == OW'(k));
      if (pick_idx == OW'(k)) begin
        pick_row  = req_row[2*k +: 2];
        pick_text = req_text[128*k +: 128];
      end
    end
  end

  // Character at the current column, char 0 in the top byte.
  always_comb begin
    cur_char = '0;
    for (int c = 0; c < 16; c++)
      if (col[3:0] == 4'(c))
        cur_char = text_q[127-8*c -: 8];
  end

  assign update_clear = 1'b0;

`ifndef OLED_ARB_AUTO_UPDATE_EN
  logic unused_upd;
  assign unused_upd   = update_ready;
  assign update_start = 1'b0;
`endif

  // Transaction sequencer with registered command outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      rr               <= '0;
      owner            <= '0;
      row_q            <= '0;
      text_q           <= '0;
      col              <= '0;
      grant            <= '0;
      done             <= '0;
      busy             <= 1'b0;
      write_start      <= 1'b0;
      write_base_addr  <= '0;
      write_ascii_data <= '0;
`ifdef OLED_ARB_AUTO_UPDATE_EN
      update_start     <= 1'b0;
`endif
    end else begin
      done        <= '0;
      write_start <= 1'b0;
`ifdef OLED_ARB_AUTO_UPDATE_EN
      update_start <= 1'b0;
`endif
      case (state)
        IDLE: if (pick_vld) begin
          grant  <= pick_oh;
          owner  <= pick_idx;
          row_q  <= pick_row;
          text_q <= pick_text;
          col    <= '0;
          busy   <= 1'b1;
          state  <= WR_ISSUE;
        end
        WR_ISSUE: if (write_ready) begin
          write_start      <= 1'b1;
          write_base_addr  <= {row_q, col[3:0], 3'b000};
          write_ascii_data <= cur_char;
          state            <= WR_HOLD;
        end
        WR_HOLD: state <= WR_WAIT;
        WR_WAIT: if (write_ready) begin
          col <= col_nx;
          if (col_nx < LC)
            state <= WR_ISSUE;
          else
`ifdef OLED_ARB_AUTO_UPDATE_EN
            state <= UPD_ISSUE;
`else
            state <= FINISH;
`endif
        end
`ifdef OLED_ARB_AUTO_UPDATE_EN
        UPD_ISSUE: if (update_ready) begin
          update_start <= 1'b1;
          state        <= UPD_HOLD;
        end
        UPD_HOLD: state <= UPD_WAIT;
        UPD_WAIT: if (update_ready) state <= FINISH;
`endif
        FINISH: begin
          done  <= owner_oh;
          grant <= '0;
          busy  <= 1'b0;
          rr    <= (owner == LAST) ? '0 : owner + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_line_arbiter.sv
// tb_oled_line_arbiter: scoreboard bench with a reference arbitration model
// and a behavioural OLED controller that stalls the ready lines randomly.
module tb_oled_line_arbiter;

  localparam int N  = 2;
  localparam int LC = 16;

  logic               clk = 1'b0;
  logic               rstn;
  logic [N-1:0]       req;
  logic [2*N-1:0]     req_row;
  logic [128*N-1:0]   req_text;
  logic [N-1:0]       grant;
  logic [N-1:0]       done;
  logic               busy;
  logic               write_start;
  logic [8:0]         write_base_addr;
  logic [7:0]         write_ascii_data;
  logic               write_ready;
  logic               update_start;
  logic               update_clear;
  logic               update_ready;

  oled_line_arbiter #(.N_REQ(N), .LINE_CHARS(LC)) dut (
    .clk(clk), .rstn(rstn),
    .req(req), .req_row(req_row), .req_text(req_text),
    .grant(grant), .done(done), .busy(busy),
    .write_start(write_start),
    .write_base_addr(write_base_addr),
    .write_ascii_data(write_ascii_data),
    .write_ready(write_ready),
    .update_start(update_start),
    .update_clear(update_clear),
    .update_ready(update_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;  // 0 write, 1 update, 2 done
    logic [8:0] addr;
    logic [7:0] data;
    int         who;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  total_starts = 0;
  int  total_updates = 0;
  int  rr_m = 0;
  logic prev_cmd = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: all bits of a pattern raised together are served
  // in rotated order from the rr pointer, one full line each.
  task automatic push_exp(input logic [N-1:0] pat);
    int last;
    last = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr_m + k) % N;
      if (pat[idx]) begin
        for (int c = 0; c < LC; c++) begin
          ev_t e;
          logic [3:0] c4;
          c4 = 4'(c);
          e.kind = 0;
          e.addr = {req_row[2*idx +: 2], c4, 3'b000};
          e.data = req_text[128*idx + 8*(15-c) +: 8];
          e.who  = idx;
          q.push_back(e);
        end
`ifdef OLED_ARB_AUTO_UPDATE_EN
        q.push_back('{1, 9'h0, 8'h0, idx});
`endif
        q.push_back('{2, 9'h0, 8'h0, idx});
        last = idx;
      end
    end
    if (last >= 0) rr_m = (last + 1) % N;
  endtask

  // OLED write engine: ready drops after a start, returns 1..4 cycles later.
  initial begin
    write_ready = 1'b0;
    repeat (50) @(posedge clk);
    #1 write_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (write_start) begin
        @(posedge clk);
        #1 write_ready = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 write_ready = 1'b1;
      end
    end
  end

  // OLED update engine.
  initial begin
    update_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (update_start) begin
        @(posedge clk);
        #1 update_ready = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 update_ready = 1'b1;
      end
    end
  end

  // Monitor: compares every command and done pulse with the scoreboard.
  always @(negedge clk) begin
    if (!rstn) begin
      check("reset_outputs",
            32'({grant, done, busy, write_start, update_start,
                 update_clear, write_base_addr, write_ascii_data}), 0);
    end else begin
      if (write_start || update_start) begin
        check("cmd_spacing", 32'(prev_cmd), 0);
        check("update_clear", 32'(update_clear), 0);
      end
      if (write_start) begin
        total_starts++;
        check("start_ready", 32'(write_ready), 1);
        check("start_excl", 32'(update_start), 0);
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write addr=%0h data=%0h",
                   write_base_addr, write_ascii_data);
        end else begin
          ev_t e;
          e = q.pop_front();
          check("write_kind", 32'(e.kind), 0);
          check("write_addr", 32'(write_base_addr), 32'(e.addr));
          check("write_data", 32'(write_ascii_data), 32'(e.data));
          check("write_grant", 32'(grant), 32'(1 << e.who));
        end
      end
      if (update_start) begin
        total_updates++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_update grant=%0h", grant);
        end else begin
          ev_t e;
          e = q.pop_front();
          check("update_kind", 32'(e.kind), 1);
          check("update_grant", 32'(grant), 32'(1 << e.who));
        end
      end
      if (|done) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done done=%0h", done);
        end else begin
          ev_t e;
          e = q.pop_front();
          check("done_kind", 32'(e.kind), 2);
          check("done_vec", 32'(done), 32'(1 << e.who));
          check("done_grant", 32'(grant), 0);
          check("done_busy", 32'(busy), 0);
        end
      end
    end
    prev_cmd = rstn && (write_start || update_start);
  end

  task automatic start_episode(input logic [N-1:0] pat);
    push_exp(pat);
    req = req | pat;
  endtask

  // Holds requests until each done; optionally drops the owner's req and
  // scrambles its text after its 5th write, or aborts at write abort_at.
  task automatic wait_episode(input logic [N-1:0] pat, input bit drop_en,
                              input int abort_at);
    logic [N-1:0] pend;
    int wc;
    int cyc;
    pend = pat;
    wc   = 0;
    cyc  = 0;
    while (pend != '0) begin
      @(negedge clk);
      cyc++;
      if (write_start) begin
        wc++;
        if (abort_at != 0 && wc == abort_at) return;
        if (drop_en && wc == 5)
          for (int i = 0; i < N; i++)
            if (grant[i]) begin
              req[i] = 1'b0;
              req_text[128*i +: 128] =
                {$urandom, $urandom, $urandom, $urandom};
            end
      end
      for (int i = 0; i < N; i++)
        if (done[i]) begin
          req[i]  = 1'b0;
          pend[i] = 1'b0;
          wc      = 0;
        end
      if (cyc > 3000) begin
        checks++; errors++;
        $display("FAIL episode_timeout pending=%0h", pend);
        return;
      end
    end
  endtask

  task automatic rand_setup();
    for (int i = 0; i < N; i++) begin
      req_row[2*i +: 2] = 2'($urandom_range(0, 3));
      req_text[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  initial begin
    logic [127:0] banner;
    logic [N-1:0] pat;
    banner   = "  AstroPix4 FW  ";
    rstn     = 1'b0;
    req      = '0;
    req_row  = '0;
    req_text = '0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;

    // Banner line on row 0 while the write engine is still busy.
    req_text[127:0] = banner;
    start_episode(2'b01);
    repeat (40) @(negedge clk);
    check("no_start_before_ready", 32'(total_starts), 0);
    check("busy_while_stalled", 32'(busy), 1);
    check("grant_while_stalled", 32'(grant), 1);
    wait_episode(2'b01, 1'b0, 0);

    // Simultaneous requests on rows 1 and 3.
    req_row = 4'b11_01;
    rand_setup();
    req_row = 4'b11_01;
    start_episode(2'b11);
    wait_episode(2'b11, 1'b0, 0);

    // Owner drops req and changes text mid-line.
    rand_setup();
    start_episode(2'b01);
    wait_episode(2'b01, 1'b1, 0);

    // Reset during the 8th write, then re-request from col 0.
    rand_setup();
    start_episode(2'b10);
    wait_episode(2'b10, 1'b0, 8);
    @(posedge clk);
    #1 rstn = 1'b0;
    req = '0;
    q.delete();
    rr_m = 0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    check("post_reset_busy", 32'(busy), 0);
    rand_setup();
    start_episode(2'b11);
    wait_episode(2'b11, 1'b0, 0);

    // Random traffic.
    for (int n = 0; n < 12; n++) begin
      rand_setup();
      pat = N'($urandom_range(1, (1 << N) - 1));
      start_episode(pat);
      wait_episode(pat, 1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    check("scoreboard_empty", 32'(q.size()), 0);
    check("idle_at_end", 32'(busy), 0);
`ifndef OLED_ARB_AUTO_UPDATE_EN
    check("no_updates", 32'(total_updates), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
